sram_rmw_ctrl: RTL and testbench

//  Sequencer for an external asynchronous SRAM (16-bit class parts) with a shared tristate data bus.

---
 rtl/sram_rmw_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sram_rmw_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_rmw_ctrl.sv
// Single-port asynchronous SRAM sequencer: READ, WRITE and read-modify-write INCREMENT over a shared tristate bus.
// Optional macro SRAM_RMW_SAT_EN makes INCREMENT saturate at all-ones instead of wrapping.
module sram_rmw_ctrl #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WAIT_CYC = 1,
    parameter int unsigned INC_STEP = 1
) (
    input  logic              clk50mhz,
    input  logic              rst,
    input  logic              req,
    input  logic [1:0]        cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    inout  wire  [DATA_W-1:0] sram_data
);

    localparam int unsigned CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [1:0]  CMD_RD  = 2'b00;
    localparam logic [1:0]  CMD_WR  = 2'b01;
    localparam logic [1:0]  CMD_INC = 2'b10;

    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_WAIT, TURN, WR_SETUP, WR_PULSE, WR_HOLD, DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [1:0]        cmd_q, cmd_nxt;
    logic [DATA_W-1:0] rd_buf, rd_buf_nxt;
    logic [DATA_W-1:0] wr_data, wr_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] inc_val;
    logic              busy_nxt, ack_nxt, we_n_nxt, oe_n_nxt;
    logic              drive, drive_nxt;

    // Bus is driven only in the write states; the model of the pins is the registered enable.
    assign sram_data = drive ? wr_data : {DATA_W{1'bz}};

`ifdef SRAM_RMW_SAT_EN
    localparam int unsigned SUM_W = DATA_W + 1;
    logic [SUM_W-1:0] inc_sum;
    always_comb begin
        inc_sum = {1'b0, rd_buf} + SUM_W'(INC_STEP);
        inc_val = inc_sum[DATA_W] ? {DATA_W{1'b1}} : inc_sum[DATA_W-1:0];
    end
`else
    always_comb begin
        inc_val = rd_buf + DATA_W'(INC_STEP);
    end
`endif

    // Every output is registered from the next state so it lines up with the state it belongs to.
    always_ff @(posedge clk50mhz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_q     <= CMD_RD;
            rd_buf    <= '0;
            wr_data   <= '0;
            rdata     <= '0;
            sram_addr <= '0;
            busy      <= 1'b0;
            ack       <= 1'b0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            drive     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cmd_q     <= cmd_nxt;
            rd_buf    <= rd_buf_nxt;
            wr_data   <= wr_nxt;
            rdata     <= rdata_nxt;
            sram_addr <= addr_nxt;
            busy      <= busy_nxt;
            ack       <= ack_nxt;
            sram_we_n <= we_n_nxt;
            sram_oe_n <= oe_n_nxt;
            drive     <= drive_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cmd_nxt    = cmd_q;
        rd_buf_nxt = rd_buf;
        wr_nxt     = wr_data;
        rdata_nxt  = rdata;
        addr_nxt   = sram_addr;

        case (state)
            IDLE: begin
                if (req) begin
                    cmd_nxt = cmd;
                    wr_nxt  = wdata;
                    if (cmd == CMD_RD || cmd == CMD_INC) begin
                        state_nxt = RD_SETUP;
                        addr_nxt  = addr;
                    end else if (cmd == CMD_WR) begin
                        state_nxt = WR_SETUP;
                        addr_nxt  = addr;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RD_SETUP: begin
                state_nxt = RD_WAIT;
                cnt_nxt   = CNT_W'(WAIT_CYC - 1);
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    rd_buf_nxt = sram_data;
                    state_nxt  = TURN;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            TURN: begin
                if (cmd_q == CMD_INC) begin
                    state_nxt = WR_SETUP;
                    wr_nxt    = inc_val;
                end else begin
                    state_nxt = DONE;
                    rdata_nxt = rd_buf;
                end
            end
            WR_SETUP: begin
                state_nxt = WR_PULSE;
                cnt_nxt   = CNT_W'(WAIT_CYC - 1);
            end
            WR_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = WR_HOLD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                state_nxt = DONE;
                if (cmd_q == CMD_INC) begin
                    rdata_nxt = rd_buf;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt  = (state_nxt != IDLE);
        ack_nxt   = (state_nxt == DONE);
        oe_n_nxt  = !(state_nxt == RD_SETUP || state_nxt == RD_WAIT);
        we_n_nxt  = (state_nxt != WR_PULSE);
        drive_nxt = (state_nxt == WR_SETUP || state_nxt == WR_PULSE || state_nxt == WR_HOLD);
    end

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Directed bench: two controllers (WAIT_CYC=1 and WAIT_CYC=3), each on its own behavioural async SRAM.
module tb_sram_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;

    logic        req1 = 1'b0, req2 = 1'b0;
    logic [1:0]  cmd1 = 2'b00, cmd2 = 2'b00;
    logic [15:0] addr1 = '0, addr2 = '0, wdata1 = '0, wdata2 = '0;
    logic        busy1, ack1, we_n1, oe_n1, busy2, ack2, we_n2, oe_n2;
    logic [15:0] rdata1, rdata2, sram_addr1, sram_addr2;
    wire  [15:0] sram_data1, sram_data2;

    logic [15:0] mem1 [0:65535];
    logic [15:0] mem2 [0:65535];
    logic        prev_oe1 = 1'b1, prev_drv1 = 1'b0, prev_oe2 = 1'b1, prev_drv2 = 1'b0;

    always #5 clk = ~clk;

    sram_rmw_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(1), .INC_STEP(1)) dut1 (
        .clk50mhz(clk), .rst(rst), .req(req1), .cmd(cmd1), .addr(addr1), .wdata(wdata1),
        .busy(busy1), .ack(ack1), .rdata(rdata1), .sram_addr(sram_addr1),
        .sram_we_n(we_n1), .sram_oe_n(oe_n1), .sram_data(sram_data1));

    sram_rmw_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(3), .INC_STEP(1)) dut2 (
        .clk50mhz(clk), .rst(rst), .req(req2), .cmd(cmd2), .addr(addr2), .wdata(wdata2),
        .busy(busy2), .ack(ack2), .rdata(rdata2), .sram_addr(sram_addr2),
        .sram_we_n(we_n2), .sram_oe_n(oe_n2), .sram_data(sram_data2));

    // Async SRAM models: output while OE low and WE high, store while WE low.
    assign sram_data1 = (!oe_n1 && we_n1) ? mem1[sram_addr1] : 16'bz;
    assign sram_data2 = (!oe_n2 && we_n2) ? mem2[sram_addr2] : 16'bz;

    always @(negedge clk) begin
        if (!we_n1) mem1[sram_addr1] = sram_data1;
        if (!we_n2) mem2[sram_addr2] = sram_data2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pin-level safety rules checked every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("we_oe_excl1", 32'(oe_n1 | we_n1), 32'd1);
            check("we_oe_excl2", 32'(oe_n2 | we_n2), 32'd1);
            check("no_drive_oe1", 32'(!oe_n1 && dut1.drive), 32'd0);
            check("no_drive_oe2", 32'(!oe_n2 && dut2.drive), 32'd0);
            check("turnaround1", 32'(dut1.drive && !prev_drv1 && !prev_oe1), 32'd0);
            check("turnaround2", 32'(dut2.drive && !prev_drv2 && !prev_oe2), 32'd0);
        end
        prev_oe1 = oe_n1; prev_drv1 = dut1.drive;
        prev_oe2 = oe_n2; prev_drv2 = dut2.drive;
    end

    // Present one request to dut1; returns at the negedge of cycle 1 after the accept edge.
    task automatic issue1(input logic [1:0] c, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        req1 = 1'b1; cmd1 = c; addr1 = a; wdata1 = d;
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0;
    endtask

    task automatic wait_ack1(input string tag, input int exp_lat);
        int n;
        n = 1;
        while (!ack1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        int ack_cnt;
        int first_ack;
        int last_ack;
        int oe_cycles;
        logic we_seen;

        for (int i = 0; i < 65536; i++) begin
            mem1[i] = 16'h0000;
            mem2[i] = 16'h0000;
        end
        mem1[16'h0020] = 16'h0007;
        mem1[16'h0040] = 16'hFFFF;
        mem2[16'h0070] = 16'h3C5A;

        // Reset values while rst is held.
        @(negedge clk);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_ack", 32'(ack1), 32'd0);
        check("rst_rdata", 32'(rdata1), 32'd0);
        check("rst_addr", 32'(sram_addr1), 32'd0);
        check("rst_we_n", 32'(we_n1), 32'd1);
        check("rst_oe_n", 32'(oe_n1), 32'd1);
        check("rst_drive", 32'(dut1.drive), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // WRITE then READ at W=1.
        issue1(2'b01, 16'h0010, 16'hA5A5);
        check("wr_busy", 32'(busy1), 32'd1);
        wait_ack1("wr_latency", 4);
        check("wr_addr", 32'(sram_addr1), 32'h0010);
        @(negedge clk);
        check("wr_ack_pulse", 32'(ack1), 32'd0);
        check("wr_idle_busy", 32'(busy1), 32'd0);
        check("wr_mem", 32'(mem1[16'h0010]), 32'hA5A5);

        issue1(2'b00, 16'h0010, 16'h0000);
        wait_ack1("rd_latency", 4);
        check("rd_rdata", 32'(rdata1), 32'hA5A5);
        @(negedge clk);
        check("rd_rdata_hold", 32'(rdata1), 32'hA5A5);

        // INCREMENT with a req pulse while busy that must be ignored.
        issue1(2'b10, 16'h0020, 16'h0000);
        ack_cnt = 0; first_ack = 0;
        for (int n = 1; n <= 12; n++) begin
            if (n == 3) begin req1 = 1'b1; cmd1 = 2'b01; addr1 = 16'h0030; wdata1 = 16'hDEAD; end
            if (n == 4) req1 = 1'b0;
            if (ack1) begin
                ack_cnt++;
                if (first_ack == 0) first_ack = n;
            end
            @(negedge clk);
        end
        check("inc_ack_count", 32'(ack_cnt), 32'd1);
        check("inc_latency", 32'(first_ack), 32'd7);
        check("inc_rdata", 32'(rdata1), 32'h0007);
        check("inc_mem", 32'(mem1[16'h0020]), 32'h0008);
        check("busy_req_ignored", 32'(mem1[16'h0030]), 32'h0000);

        // INCREMENT at the top of the range.
        issue1(2'b10, 16'h0040, 16'h0000);
        wait_ack1("inc_top_latency", 7);
        check("inc_top_rdata", 32'(rdata1), 32'hFFFF);
`ifdef SRAM_RMW_SAT_EN
        check("inc_top_mem", 32'(mem1[16'h0040]), 32'hFFFF);
`else
        check("inc_top_mem", 32'(mem1[16'h0040]), 32'h0000);
`endif

        // Reserved command: immediate ack, no access, rdata untouched.
        issue1(2'b11, 16'h0055, 16'h1234);
        check("rsv_ack", 32'(ack1), 32'd1);
        check("rsv_we_n", 32'(we_n1), 32'd1);
        check("rsv_oe_n", 32'(oe_n1), 32'd1);
        check("rsv_rdata", 32'(rdata1), 32'hFFFF);
        @(negedge clk);
        check("rsv_ack_pulse", 32'(ack1), 32'd0);

        // Reset in the middle of the WE pulse.
        issue1(2'b01, 16'h0060, 16'hBEEF);
        @(negedge clk);
        check("abort_in_pulse", 32'(we_n1), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("abort_we_n", 32'(we_n1), 32'd1);
        check("abort_drive", 32'(dut1.drive), 32'd0);
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_rdata", 32'(rdata1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ack_cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (ack1 || busy1) ack_cnt++;
        end
        check("abort_no_ack", 32'(ack_cnt), 32'd0);

        // W=3 back-to-back READs with req held high.
        @(negedge clk);
        req2 = 1'b1; cmd2 = 2'b00; addr2 = 16'h0070;
        we_seen = 1'b0;
        ack_cnt = 0; first_ack = 0; last_ack = 0; oe_cycles = 0;
        for (int n = 1; n <= 27; n++) begin
            @(negedge clk);
            if (ack2) begin
                ack_cnt++;
                if (first_ack == 0) first_ack = n;
                if (last_ack != 0) check("b2b_spacing", 32'(n - last_ack), 32'd7);
                last_ack = n;
            end
            if (!oe_n2) oe_cycles++;
            if (!we_n2) we_seen = 1'b1;
            if (n == 27) req2 = 1'b0;
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ack2) ack_cnt++;
        end
        check("b2b_ack_count", 32'(ack_cnt), 32'd4);
        check("b2b_first_ack", 32'(first_ack), 32'd6);
        check("b2b_last_ack", 32'(last_ack), 32'd27);
        check("b2b_oe_cycles", 32'(oe_cycles), 32'd16);
        check("b2b_no_write", 32'(we_seen), 32'd0);
        check("b2b_rdata", 32'(rdata2), 32'h3C5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
